// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Takes a framed byte stream (LEN_LO, LEN_HI, 4*N data bytes, CSUM),
// assembles little-endian words and writes them to consecutive word
// addresses. The CPU stays held until a checksum-verified image is in.
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    // 17 bits so a 16-bit length can be compared without overflow
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [1:0]  bcnt;
    logic [15:0] wcnt;
    logic [23:0] asm_q;   // first three bytes of the word being assembled
    logic [7:0]  csum;
    logic        xfer;

    assign xfer = byte_valid && byte_ready;

    // Loader FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            len_lo     <= '0;
            len        <= '0;
            bcnt       <= '0;
            wcnt       <= '0;
            asm_q      <= '0;
            csum       <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        bcnt       <= '0;
                        wcnt       <= '0;
                        csum       <= '0;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        state      <= S_LEN0;
                    end
                end
                S_LEN0: begin
                    if (xfer) begin
                        len_lo <= byte_data;
                        state  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        len <= {byte_data, len_lo};
                        if ({byte_data, len_lo} == 16'd0) begin
                            state <= S_CSUM;
                        end else if ({1'b0, byte_data, len_lo} > DEPTH_L) begin
                            // oversize image: refuse before any write
                            byte_ready <= 1'b0;
                            error      <= 1'b1;
                            state      <= S_ERR;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum <= csum ^ byte_data;
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            wr_en   <= 1'b1;
                            wr_data <= {byte_data, asm_q};
                            wr_addr <= WIDTH'(wcnt);
                            wcnt    <= wcnt + 16'd1;
                            if (wcnt == len - 16'd1)
                                state <= S_CSUM;
                        end else begin
                            asm_q <= {byte_data, asm_q[23:8]};
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        if (byte_data == csum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            error <= 1'b1;
                            state <= S_ERR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares them whenever wr_en is seen.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, wr_en, cpu_hold, done, error;
    logic [31:0] wr_addr, wr_data;

    imem_loader #(.WIDTH(32), .DEPTH(1024)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int          ncmp = 0;
    int          nerr = 0;
    int          cyc = 0;
    logic [63:0] exp_q[$];   // {addr, data}
    logic [7:0]  run_cs;
    logic        cont = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        ncmp++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    // Write monitor
    logic prev_we = 1'b0;
    logic have_last = 1'b0;
    int   last_cyc = 0;
    always @(negedge clk) begin
        logic [63:0] e;
        if (wr_en) begin
            chk("wr_en_single_cycle", {31'b0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e[63:32]);
                chk("wr_data", wr_data, e[31:0]);
            end
            if (cont && have_last) chk("wr_gap_cycles", 32'(cyc - last_cyc), 32'd4);
            last_cyc = cyc;
            have_last = cont;
        end
        if (!cont) have_last = 1'b0;
        prev_we = wr_en;
    end

    // Present one byte until accepted, then idle byte_valid for gap cycles
    task automatic send(input logic [7:0] b, input int gap);
        logic rdy;
        int   n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        do begin
            rdy = byte_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 100);
        byte_valid = 1'b0;
        if (!rdy) begin
            ncmp++;
            nerr++;
            $display("FAIL byte_accept_timeout: byte %h not accepted in 100 cycles", b);
        end
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            run_cs = run_cs ^ w[8*k +: 8];
            send(w[8*k +: 8], gap);
        end
    endtask

    task automatic hdr(input int n, input int gap);
        run_cs = 8'h00;
        send(n[7:0], gap);
        send(n[15:8], gap);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_after_start", {31'b0, byte_ready}, 32'd1);
        chk("hold_after_start", {31'b0, cpu_hold}, 32'd1);
        chk("done_after_start", {31'b0, done}, 32'd0);
        chk("error_after_start", {31'b0, error}, 32'd0);
    endtask

    task automatic chk_status(input string nm, input logic d, input logic e, input logic h);
        chk({nm, "_done"}, {31'b0, done}, {31'b0, d});
        chk({nm, "_error"}, {31'b0, error}, {31'b0, e});
        chk({nm, "_hold"}, {31'b0, cpu_hold}, {31'b0, h});
        chk({nm, "_ready"}, {31'b0, byte_ready}, 32'd0);
    endtask

    task automatic full_image(input bit mid_hold_check);
        logic [31:0] w;
        cont = 1'b1;
        hdr(1024, 0);
        for (int i = 0; i < 1024; i++) begin
            w = 32'h1000_0000 + 32'(i);
            exp_q.push_back({32'(i), w});
            send_word(w, 0);
            if (mid_hold_check && i == 512) chk("reload_hold_mid", {31'b0, cpu_hold}, 32'd1);
        end
        send(run_cs, 0);
        cont = 1'b0;
        chk("full_last_addr", wr_addr, 32'd1023);
        chk_status("full", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, byte_ready}, 32'd0);
        chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk_status("rst", 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        // two-word image, good checksum
        do_start();
        hdr(2, 0);
        exp_q.push_back({32'd0, 32'h2008_0005});
        send_word(32'h2008_0005, 0);
        exp_q.push_back({32'd1, 32'h0000_0000});
        send_word(32'h0000_0000, 0);
        send(8'h2D, 0);
        chk_status("t1", 1'b1, 1'b0, 1'b0);

        // same image, bad checksum: writes stay, error raised
        do_start();
        hdr(2, 0);
        exp_q.push_back({32'd0, 32'h2008_0005});
        send_word(32'h2008_0005, 0);
        exp_q.push_back({32'd1, 32'h0000_0000});
        send_word(32'h0000_0000, 0);
        send(8'h00, 0);
        chk_status("t2", 1'b0, 1'b1, 1'b1);

        // oversize length 1025: error right after LEN_HI, no writes
        do_start();
        send(8'h01, 0);
        send(8'h04, 0);
        chk_status("t3", 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // single word with 3-cycle valid gaps between every byte
        do_start();
        hdr(1, 3);
        exp_q.push_back({32'd0, 32'h1234_5678});
        send_word(32'h1234_5678, 3);
        send(8'h08, 0);
        chk_status("t4", 1'b1, 1'b0, 1'b0);

        // reset after two data bytes: partial word dropped
        do_start();
        hdr(1, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("midrst_wr_addr", wr_addr, 32'd0);
        chk("midrst_wr_data", wr_data, 32'd0);
        chk_status("midrst", 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        do_start();
        hdr(1, 0);
        exp_q.push_back({32'd0, 32'hDEAD_BEEF});
        send_word(32'hDEAD_BEEF, 0);
        send(8'h22, 0);
        chk_status("t5", 1'b1, 1'b0, 1'b0);

        // empty image needs checksum 0x00
        do_start();
        hdr(0, 0);
        send(8'h00, 0);
        chk_status("t6", 1'b1, 1'b0, 1'b0);

        // full-depth image streamed back to back, then reload from DONE
        do_start();
        full_image(1'b0);
        do_start();
        full_image(1'b1);

        repeat (4) @(posedge clk);
        #1;
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Accepts a framed byte stream (from the serial receiver), assembles little-endian 32-bit instruction words, and drives the instruction memory write port at consecutive word addresses. Holds the CPU stalled until a complete, checksum-verified image is loaded. Sits between the byte-stream source and the instruction memory; the CPU-side read port is unaffected.

## Interface

- Parameters
  - WIDTH, 32: instruction word width and write-address width; fixed at 32 (four bytes per word).
  - DEPTH, 1024: instruction memory depth in words; maximum accepted word count.
- Ports
  - clk  in  1  single clock; all logic rising-edge.
  - rst  in  1  reset; synchronous and active-high.
  - start  in  1  begin a load; sampled only in IDLE, DONE, ERR.
  - byte_valid  in  1  byte_data is valid.
  - byte_data  in  8  stream byte.
  - byte_ready  out  1  loader accepts a byte this cycle.
  - wr_en  out  1  one-cycle write strobe to the instruction memory.
  - wr_addr  out  WIDTH  word index; matches the read-port indexing `mem[address]`.
  - wr_data  out  WIDTH  assembled instruction word.
  - cpu_hold  out  1  keeps the CPU stalled.
  - done  out  1  image loaded and verified.
  - error  out  1  load failed: length or checksum.

## Operation

- Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes, then one CSUM byte. Word byte k maps to bits [8k+7:8k].
- A byte transfers on a cycle with byte_valid && byte_ready.
- States:
  - IDLE: byte_ready=0. On start, clear counters and checksum, then go to LEN0.
  - LEN0: byte_ready=1. Latch LEN_LO, then go to LEN1.
  - LEN1: byte_ready=1. Latch LEN_HI.
    - N==0: go to CSUM.
    - N>DEPTH: go to ERR with no writes.
    - Otherwise: go to DATA.
  - DATA: byte_ready=1. Shift each byte into a 32-bit assembly register and XOR it into an 8-bit running checksum.
    - On the 4th byte of a word, register wr_data and wr_addr and pulse wr_en, then advance the word counter.
    - After word N-1, go to CSUM.
  - CSUM: byte_ready=1. Compare the received byte against the running checksum. Equal: go to DONE. Unequal: go to ERR.
  - DONE: done=1, cpu_hold=0. A start restarts the load (go to LEN0, cpu_hold=1, done=0).
  - ERR: error=1, cpu_hold=1. Start restarts as from DONE.
- The checksum covers data bytes only; length bytes are excluded. N==0 requires CSUM 0x00.
- Words written before a checksum failure remain in memory. There is no rollback.
- start while in LEN0/LEN1/DATA/CSUM is ignored.
- The byte counter wraps 0..3. The word counter runs 0..N-1, and wr_addr equals the counter value at the write.

## Timing

- Reset values: state IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, counters and checksum 0.
- start sampled high in IDLE → byte_ready=1 on the next cycle.
- wr_en asserts exactly one cycle after the clock edge that accepts the 4th byte of a word. It lasts one cycle, with wr_addr and wr_data stable during it. wr_data and wr_addr hold their last values otherwise.
- Back-to-back bytes are accepted every cycle (byte_ready stays 1); no stall between words.
- The byte_valid low gaps anywhere in a frame are tolerated. State and partial word are held.
- done/error/cpu_hold change on the cycle after the CSUM byte is accepted, or after the LEN_HI byte for the length error.
- rst mid-load: next cycle is in IDLE with reset values. The partial word is discarded and no wr_en is issued.

## Test plan

- N=2, words 0x20080005 and 0x00000000, CSUM=0x2D → wr_en at addr 0 with data 0x20080005, then at addr 1 with data 0x00000000. done=1, cpu_hold=0, error=0.
- Same frame with CSUM=0x00 → both writes occur, error=1, done=0, cpu_hold=1.
- LEN=0x0401 (1025) with DEPTH=1024 → error=1 the cycle after LEN_HI, no wr_en, byte_ready=0.
- N=1 with byte_valid toggled low for 3 cycles between each byte → a single write of the correct word at addr 0 after the 4th byte. CSUM correct → done=1.
- rst pulsed after 2 data bytes of word 0 → no wr_en, and all outputs at reset values next cycle. A fresh frame with start then loads correctly from addr 0.
- N=DEPTH full image streamed continuously → wr_en every 4th cycle, last at addr 1023, then done=1. A second start from DONE reloads, with cpu_hold=1 during the reload.
